// File: rtl/uart_tx.sv
// uart_tx: parameterised UART transmitter (5..8 data bits, optional parity,
// 1 or 2 stop bits). Bit timing comes from the rising edges of baud_clk.
//
// Ports:
//   clk       system clock, all state updates on its rising edge
//   rst       synchronous active-low reset
//   baud_clk  divided bit-rate clock, synchronous to clk
//   tx_data   frame payload, sampled when a frame is accepted
//   tx_valid  request to send tx_data
//   tx_ready  high while a new frame can be accepted (IDLE only)
//   tx        serial line, idle high, registered
//   busy      high from acceptance until the frame ends
//   tx_done   one-cycle pulse when the final stop bit completes
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 baud_q;
  logic                 tick;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 last_bit;
  logic                 last_stop;

  // One-cycle strobe per baud_clk rising edge.
  assign tick      = baud_clk & ~baud_q;
  assign last_bit  = (cnt_q == CNT_W'(DATA_BITS - 1));
  // stop_q marks that the first of two stop bits has already elapsed.
  assign last_stop = (STOP_BITS == 1) || stop_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs; baud_q resets high so a baud_clk that
  // is already high at reset release does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_q  <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      baud_q  <= baud_clk;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update. IDLE ignores tick, so a tick coincident
  // with acceptance is not consumed and SYNC waits for the following one.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = '0;
          par_d   = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
          stop_d  = 1'b0;
          state_d = S_SYNC;
        end
      end
      S_SYNC:   if (tick) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP: begin
        if (tick) begin
          if (last_stop) state_d = S_IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up
  // with the state they describe.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule
